csp_channel_receiver: RTL

CSP_CHANNEL_RECEIVER -- requirements
Module: csp_channel_receiver

---
 rtl/csp_channel_pkg.sv | 20 ++
 rtl/csp_channel_receiver_if.sv | 48 ++++
 rtl/csp_sync_fifo.sv | 90 +++++++++
 rtl/csp_channel_receiver.sv | 114 +++++++++++
 4 files changed

// File: rtl/csp_channel_pkg.sv
// Shared definitions for the CSP four-phase channel blocks (receiver and
// transmitter). The channel word is signed: MSB set means "neutral" (no
// token), MSB clear means a valid token whose payload is the lower bits.
package csp_channel_pkg;

    // Handshake phase of a channel consumer.
    //   S_NEUTRAL : enable low, waiting to observe neutral before requesting
    //   S_REQ     : enable high, waiting for a valid token
    //   S_RELEASE : enable low, waiting for the producer to return to neutral
    typedef enum logic [1:0] {
        S_NEUTRAL = 2'd0,
        S_REQ     = 2'd1,
        S_RELEASE = 2'd2
    } csp_state_t;

    // Canonical neutral word; cast to the channel width at the point of use
    // (all ones, i.e. -1).
    localparam int NEUTRAL = -1;

endpackage

// File: rtl/csp_channel_receiver_if.sv
// Signal bundle between a CSP channel receiver and its environment.
// Handshakes carried here:
//   channel side : four-phase. The receiver raises L_enable, the producer
//                  presents a token (L_data >= 0), the receiver drops
//                  L_enable, the producer returns L_data to neutral (< 0).
//                  At most one token is outstanding.
//   output side  : valid/ready. A transfer happens on every clock edge where
//                  out_valid and out_ready are both high; out_valid never
//                  depends on out_ready and out_data is stable while
//                  out_valid is high and not yet accepted.
interface csp_channel_receiver_if
    import csp_channel_pkg::*;
#(
    parameter int BIT_WIDTH = 1
);
    logic signed [BIT_WIDTH:0] L_data;
    logic                      L_enable;
    logic [BIT_WIDTH-1:0]      out_data;
    logic                      out_valid;
    logic                      out_ready;
    logic [31:0]               num_toks;
    logic                      proto_err;
    csp_state_t                dbg_state;

    // Environment side: producer of channel words and consumer of outputs.
    modport master (
        output L_data,
        output out_ready,
        input  L_enable,
        input  out_data,
        input  out_valid,
        input  num_toks,
        input  proto_err,
        input  dbg_state
    );

    // Receiver side.
    modport slave (
        input  L_data,
        input  out_ready,
        output L_enable,
        output out_data,
        output out_valid,
        output num_toks,
        output proto_err,
        output dbg_state
    );
endinterface

// File: rtl/csp_sync_fifo.sv
// Single-clock circular-buffer FIFO with a registered head. The head register
// always holds the oldest entry, so dout has no combinational path from din,
// and it keeps its last value once the FIFO drains. Push and pop in the same
// cycle are legal at any fill level, including full and empty.
module csp_sync_fifo #(
    parameter int  WIDTH = 1,
    parameter int  DEPTH = 4,
    localparam int CNT_W = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] din,
    input  logic             ready,
    output logic             valid,
    output logic [WIDTH-1:0] dout,
    output logic [CNT_W-1:0] count,
    output logic             pop
);
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W-1:0] wr_ptr;
    logic [CNT_W-1:0] cnt;
    logic [WIDTH-1:0] head;
    logic [WIDTH-1:0] head_nxt;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    // A pop request on an empty FIFO is simply ignored.
    assign pop   = (cnt != '0) && ready;
    assign valid = (cnt != '0);
    assign dout  = head;
    assign count = cnt;

    // Storage write; entries need no reset because cnt gates their use.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= din;
        end
    end

    // Pointers and occupancy count.
    always_ff @(posedge clk) begin
        if (rst) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            cnt    <= '0;
        end else begin
            if (push) begin
                wr_ptr <= ptr_inc(wr_ptr);
            end
            if (pop) begin
                rd_ptr <= ptr_inc(rd_ptr);
            end
            case ({push, pop})
                2'b10:   cnt <= cnt + CNT_W'(1);
                2'b01:   cnt <= cnt - CNT_W'(1);
                default: cnt <= cnt;
            endcase
        end
    end

    // Next head: the entry behind the current head on a pop, or the incoming
    // word when it becomes the only entry; otherwise hold.
    always_comb begin
        head_nxt = head;
        if (pop) begin
            if (cnt > CNT_W'(1)) begin
                head_nxt = mem[ptr_inc(rd_ptr)];
            end else if (push) begin
                head_nxt = din;
            end
        end else if ((cnt == '0) && push) begin
            head_nxt = din;
        end
    end

    // Head register.
    always_ff @(posedge clk) begin
        if (rst) begin
            head <= '0;
        end else begin
            head <= head_nxt;
        end
    end
endmodule

// File: rtl/csp_channel_receiver.sv
// CSP channel receiver: consumes tokens from a four-phase signed channel and
// queues their payloads in a FIFO for a valid/ready consumer. A FIFO slot is
// reserved before L_enable is raised, so the FIFO can never overflow.
// DEPTH is expected in 2..64; BIT_WIDTH must match the interface instance.
module csp_channel_receiver
    import csp_channel_pkg::*;
#(
    parameter int BIT_WIDTH = 1,
    parameter int DEPTH     = 4
) (
    input  logic                  CLK,
    input  logic                  RESET,
    csp_channel_receiver_if.slave bus
);
    localparam int CNT_W = $clog2(DEPTH + 1);

    csp_state_t       state_q;
    csp_state_t       state_nxt;
    logic             neutral_in;
    logic             push;
    logic             pop;
    logic             space_ok;
    logic [CNT_W-1:0] fifo_count;
    logic             en_q;
    logic             seen_neutral_q;
    logic             proto_err_q;
    logic [31:0]      num_toks_q;

    // Sign bit of the channel word: set means neutral.
    assign neutral_in = bus.L_data[BIT_WIDTH];

    // Room for one more token once this cycle's pop (if any) has happened.
    assign space_ok = (fifo_count < CNT_W'(DEPTH)) || pop;

    // Next-state and push decode.
    always_comb begin
        state_nxt = state_q;
        push      = 1'b0;
        unique case (state_q)
            S_NEUTRAL: begin
                if (neutral_in && space_ok) begin
                    state_nxt = S_REQ;
                end
            end
            S_REQ: begin
                if (!neutral_in) begin
                    push      = 1'b1;
                    state_nxt = S_RELEASE;
                end
            end
            S_RELEASE: begin
                if (neutral_in) begin
                    state_nxt = S_NEUTRAL;
                end
            end
            default: state_nxt = S_NEUTRAL;
        endcase
    end

    // State register and registered enable (high exactly while in S_REQ).
    always_ff @(posedge CLK) begin
        if (RESET) begin
            state_q <= S_NEUTRAL;
            en_q    <= 1'b0;
        end else begin
            state_q <= state_nxt;
            en_q    <= (state_nxt == S_REQ);
        end
    end

    // Protocol monitor: a token showing up in S_NEUTRAL is only an error once
    // a neutral word has been seen since reset, so a token still lingering on
    // the wire right after reset is tolerated.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            seen_neutral_q <= 1'b0;
            proto_err_q    <= 1'b0;
        end else begin
            seen_neutral_q <= seen_neutral_q || neutral_in;
            if ((state_q == S_NEUTRAL) && !neutral_in && seen_neutral_q) begin
                proto_err_q <= 1'b1;
            end
        end
    end

    // Captured-token counter, wraps modulo 2^32.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            num_toks_q <= '0;
        end else if (push) begin
            num_toks_q <= num_toks_q + 32'd1;
        end
    end

    csp_sync_fifo #(
        .WIDTH (BIT_WIDTH),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (CLK),
        .rst   (RESET),
        .push  (push),
        .din   (bus.L_data[BIT_WIDTH-1:0]),
        .ready (bus.out_ready),
        .valid (bus.out_valid),
        .dout  (bus.out_data),
        .count (fifo_count),
        .pop   (pop)
    );

    assign bus.L_enable  = en_q;
    assign bus.num_toks  = num_toks_q;
    assign bus.proto_err = proto_err_q;
    assign bus.dbg_state = state_q;
endmodule
